// File: rtl/maprom_reset_pkg.sv
// Shared types for the MapROM reset supervisor: FSM states and hold-level codes.
package maprom_reset_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    EVAL = 2'd2
  } state_t;

  typedef logic [1:0] level_t;

  localparam level_t LVL_IGNORE = 2'd0;
  localparam level_t LVL_WARM   = 2'd1;
  localparam level_t LVL_CLEAR  = 2'd2;
  localparam level_t LVL_MODE   = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs; reset value chosen
// so the output reads as the input's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK_E,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK_E or negedge RESET) begin
    if (!RESET) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/maprom_reset_supervisor.sv
// Measures /RESET hold time in E-clock cycles and maps it to glitch-reject,
// warm-reset, MapROM-clear or boot-mode-advance actions.
module maprom_reset_supervisor
  import maprom_reset_pkg::*;
#(
  parameter int CNT_WIDTH  = 22,
  parameter int T_MIN      = 4,
  parameter int T_CLEAR    = 709379,
  parameter int T_MODE     = 2128137,
  parameter int NUM_MODES  = 4,
  parameter int MODE_WIDTH = $clog2(NUM_MODES)
) (
  input  logic                  CLK_E,
  input  logic                  RESET,
  input  logic                  SYS_RST_n,
  input  logic                  MAPROM_WRITTEN,
  output logic                  MAPROM_ENABLE,
  output logic                  CLEAR_MAPROM,
  output logic [MODE_WIDTH-1:0] MODE,
  output logic [1:0]            HOLD_LEVEL,
  output logic                  BUSY
);

  localparam longint CNT_LIMIT = (longint'(1) << CNT_WIDTH) - 1;

  if (!(T_MIN >= 1 && T_MIN < T_CLEAR && T_CLEAR < T_MODE &&
        longint'(T_MODE) <= CNT_LIMIT && NUM_MODES >= 2)) begin : g_param_check
    $error("maprom_reset_supervisor: illegal threshold or mode parameters");
  end

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0]  T_MIN_C   = CNT_WIDTH'(T_MIN);
  localparam logic [CNT_WIDTH-1:0]  T_CLEAR_C = CNT_WIDTH'(T_CLEAR);
  localparam logic [CNT_WIDTH-1:0]  T_MODE_C  = CNT_WIDTH'(T_MODE);
  localparam logic [MODE_WIDTH-1:0] LAST_MODE = MODE_WIDTH'(NUM_MODES - 1);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   rst_s;
  level_t                 level;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .CLK_E (CLK_E),
    .RESET (RESET),
    .d     (SYS_RST_n),
    .q     (rst_s)
  );

  // NOTE: the if/else chain assigns level on every path, so no latch is inferred.
  always_comb begin
    if (cnt < T_MIN_C)        level = LVL_IGNORE;
    else if (cnt < T_CLEAR_C) level = LVL_WARM;
    else if (cnt < T_MODE_C)  level = LVL_CLEAR;
    else                      level = LVL_MODE;
  end

  assign HOLD_LEVEL = (state == HOLD) ? level : LVL_IGNORE;
  assign BUSY       = (state != RUN);

  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK_E or negedge RESET) begin
    if (!RESET) begin
      state         <= RUN;
      cnt           <= '0;
      MAPROM_ENABLE <= 1'b0;
      CLEAR_MAPROM  <= 1'b0;
      MODE          <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!rst_s) begin
            state <= HOLD;
            cnt   <= CNT_WIDTH'(1);
          end
        end
        HOLD: begin
          if (!rst_s) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_WIDTH'(1);
          end else begin
            state <= EVAL;
            // Action is committed on the release edge, decoded from the final count.
            case (level)
              LVL_WARM:  MAPROM_ENABLE <= MAPROM_WRITTEN;
              LVL_CLEAR: begin
                CLEAR_MAPROM  <= 1'b1;
                MAPROM_ENABLE <= 1'b0;
              end
              LVL_MODE: begin
                CLEAR_MAPROM  <= 1'b1;
                MAPROM_ENABLE <= 1'b0;
                MODE          <= (MODE == LAST_MODE) ? '0 : MODE + MODE_WIDTH'(1);
              end
              default: ;
            endcase
          end
        end
        EVAL: begin
          state        <= RUN;
          CLEAR_MAPROM <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_maprom_reset_supervisor.sv
// Self-checking bench: directed and random /RESET holds compared against an
// outcome model derived from hold duration alone.
module tb_maprom_reset_supervisor;

  localparam int CNT_WIDTH = 6;
  localparam int T_MIN     = 4;
  localparam int T_CLEAR   = 16;
  localparam int T_MODE    = 32;
  localparam int NUM_MODES = 3;
  localparam int MODE_W    = $clog2(NUM_MODES);
  localparam int CNT_SAT   = 63;

  logic              CLK_E;
  logic              RESET;
  logic              SYS_RST_n;
  logic              MAPROM_WRITTEN;
  logic              MAPROM_ENABLE;
  logic              CLEAR_MAPROM;
  logic [MODE_W-1:0] MODE;
  logic [1:0]        HOLD_LEVEL;
  logic              BUSY;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: what the outputs should hold between events.
  logic m_enable;
  int   m_mode;

  maprom_reset_supervisor #(
    .CNT_WIDTH (CNT_WIDTH),
    .T_MIN     (T_MIN),
    .T_CLEAR   (T_CLEAR),
    .T_MODE    (T_MODE),
    .NUM_MODES (NUM_MODES)
  ) dut (
    .CLK_E          (CLK_E),
    .RESET          (RESET),
    .SYS_RST_n      (SYS_RST_n),
    .MAPROM_WRITTEN (MAPROM_WRITTEN),
    .MAPROM_ENABLE  (MAPROM_ENABLE),
    .CLEAR_MAPROM   (CLEAR_MAPROM),
    .MODE           (MODE),
    .HOLD_LEVEL     (HOLD_LEVEL),
    .BUSY           (BUSY)
  );

  initial CLK_E = 1'b0;
  always #5 CLK_E = ~CLK_E;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge CLK_E);
  endtask

  function automatic int lvl_of(input int d);
    int c;
    c = (d > CNT_SAT) ? CNT_SAT : d;
    if (c < T_MIN)   return 0;
    if (c < T_CLEAR) return 1;
    if (c < T_MODE)  return 2;
    return 3;
  endfunction

  // Returns 1 when the outcome pulses CLEAR_MAPROM.
  function automatic logic apply(input int lvl, input logic wr);
    case (lvl)
      1: begin m_enable = wr; return 1'b0; end
      2: begin m_enable = 1'b0; return 1'b1; end
      3: begin m_enable = 1'b0; m_mode = (m_mode + 1) % NUM_MODES; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  // Drives /RESET low for exactly d CLK_E edges and checks the resulting action.
  task automatic do_hold(input int d, input logic wr, input string tag);
    logic exp_clr;
    int   exp_cnt;
    MAPROM_WRITTEN = wr;
    SYS_RST_n      = 1'b0;
    repeat (d) tick();
    SYS_RST_n = 1'b1;
    tick();
    tick();
    exp_cnt = (d > CNT_SAT) ? CNT_SAT : d;
    check({tag, "_busy_hold"}, BUSY, 1);
    check({tag, "_level"},     HOLD_LEVEL, lvl_of(d));
    check({tag, "_cnt"},       dut.cnt, exp_cnt);
    check({tag, "_en_before"}, MAPROM_ENABLE, m_enable);
    exp_clr = apply(lvl_of(d), wr);
    tick();
    check({tag, "_clr"},       CLEAR_MAPROM, exp_clr);
    check({tag, "_en"},        MAPROM_ENABLE, m_enable);
    check({tag, "_mode"},      MODE, m_mode);
    check({tag, "_busy_eval"}, BUSY, 1);
    check({tag, "_lvl_eval"},  HOLD_LEVEL, 0);
    tick();
    check({tag, "_clr_done"},  CLEAR_MAPROM, 0);
    check({tag, "_busy_run"},  BUSY, 0);
    tick();
  endtask

  initial begin
    int d;
    int boundaries[8] = '{3, 4, 15, 16, 31, 32, 63, 70};
    logic exp_clr;

    RESET          = 1'b0;
    SYS_RST_n      = 1'b1;
    MAPROM_WRITTEN = 1'b0;
    m_enable       = 1'b0;
    m_mode         = 0;
    tick();
    tick();
    check("rst_enable", MAPROM_ENABLE, 0);
    check("rst_clear",  CLEAR_MAPROM, 0);
    check("rst_mode",   MODE, 0);
    check("rst_level",  HOLD_LEVEL, 0);
    check("rst_busy",   BUSY, 0);
    RESET = 1'b1;
    tick();
    tick();

    // Glitch, warm, and threshold boundaries at T_CLEAR.
    do_hold(2,  1'b1, "glitch");
    do_hold(10, 1'b1, "warm10");
    do_hold(15, 1'b0, "warm15");
    do_hold(15, 1'b1, "warm15b");
    do_hold(16, 1'b1, "clear16");

    // Mode cycling, saturating the counter on the longer holds.
    do_hold(40, 1'b1, "mode_a");
    do_hold(40, 1'b1, "mode_b");
    do_hold(40, 1'b1, "mode_c");
    do_hold(70, 1'b1, "mode_d");

    // Random holds, mixing exact threshold values with arbitrary lengths.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(1, 0) == 1) d = boundaries[$urandom_range(7, 0)];
      else d = int'($urandom_range(70, 1));
      do_hold(d, 1'($urandom_range(1, 0)), $sformatf("rnd%0d_d%0d", i, d));
    end

    // Make the block-reset effect visible: nonzero mode and enabled MapROM.
    if (m_mode == 0) do_hold(40, 1'b1, "pre_rst_mode");
    do_hold(8, 1'b1, "pre_rst_warm");

    // Block reset mid-hold at cnt = 20 aborts the measurement.
    SYS_RST_n = 1'b0;
    repeat (22) tick();
    check("midrst_cnt", dut.cnt, 20);
    RESET = 1'b0;
    #1;
    m_enable = 1'b0;
    m_mode   = 0;
    check("midrst_enable", MAPROM_ENABLE, 0);
    check("midrst_clear",  CLEAR_MAPROM, 0);
    check("midrst_mode",   MODE, 0);
    check("midrst_level",  HOLD_LEVEL, 0);
    check("midrst_busy",   BUSY, 0);
    SYS_RST_n = 1'b1;
    tick();
    tick();
    RESET = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("postrst_clr%0d", k),  CLEAR_MAPROM, 0);
      check($sformatf("postrst_busy%0d", k), BUSY, 0);
    end
    check("postrst_mode", MODE, 0);

    // /RESET re-asserted during EVAL: first event fires, new hold starts 2 edges later.
    MAPROM_WRITTEN = 1'b1;
    SYS_RST_n      = 1'b0;
    repeat (20) tick();
    SYS_RST_n = 1'b1;
    tick();
    SYS_RST_n = 1'b0;
    tick();
    check("reent_level", HOLD_LEVEL, lvl_of(20));
    exp_clr = apply(lvl_of(20), 1'b1);
    tick();
    check("reent_clr",   CLEAR_MAPROM, exp_clr);
    check("reent_en",    MAPROM_ENABLE, m_enable);
    check("reent_busy",  BUSY, 1);
    tick();
    check("reent_clr_done", CLEAR_MAPROM, 0);
    check("reent_run",      BUSY, 0);
    tick();
    check("reent_hold", BUSY, 1);
    check("reent_cnt1", dut.cnt, 1);
    repeat (8) tick();
    SYS_RST_n = 1'b1;
    tick();
    tick();
    check("reent2_cnt",   dut.cnt, 11);
    check("reent2_level", HOLD_LEVEL, lvl_of(11));
    exp_clr = apply(lvl_of(11), 1'b1);
    tick();
    check("reent2_clr",  CLEAR_MAPROM, exp_clr);
    check("reent2_en",   MAPROM_ENABLE, m_enable);
    check("reent2_mode", MODE, m_mode);
    tick();
    check("reent2_idle", BUSY, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
